// File: rtl/gemm_tile_writer_if.sv
// AXI write-channel bundle (AW, W, B) between the tile writer and the MIG port.
// The master drives address, data and bready; the slave returns readies and response.
interface gemm_tile_writer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 1024
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awaddr, awlen, awvalid,
      output wdata, wstrb, wlast, wvalid,
      output bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awlen, awvalid,
      input  wdata, wstrb, wlast, wvalid,
      input  bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/gemm_tile_writer.sv
// Drains one systolic-array output tile to DRAM as a sequence of AXI bursts.
// One burst is in flight at a time; bursts never cross a 4 KB page.
module gemm_tile_writer #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 1024,
   parameter int DATA_PRECISION = 16,
   parameter int SYS_ARR_SIZE   = 32,
   parameter int TILE_WIDTH     = DATA_PRECISION*SYS_ARR_SIZE*SYS_ARR_SIZE,
   parameter int NUM_BEATS      = TILE_WIDTH/DATA_WIDTH,
   parameter int MAX_BURST_LEN  = 8,
   parameter int BEAT_BYTES     = DATA_WIDTH/8,
   parameter bit REVERSE_LANES  = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [ADDR_WIDTH-1:0]       base_addr_i,
   input  logic [$clog2(NUM_BEATS):0]  num_beats_i,
   input  logic [TILE_WIDTH-1:0]       tile_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   gemm_tile_writer_if.master          axi
);

   localparam int LANES = DATA_WIDTH/DATA_PRECISION;
   localparam int OFF_W = $clog2(BEAT_BYTES);
   localparam int CNT_W = $clog2(NUM_BEATS)+1;
   localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [TILE_WIDTH-1:0] tile_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CNT_W-1:0]      total_q;
   logic [CNT_W-1:0]      sent_q;
   logic [7:0]            beat_q;
   logic [7:0]            len_q;
   logic                  err_q;

   logic [CNT_W-1:0]      clamp;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [12:0]           to_bound;
   logic [12:0]           rem;
   logic [12:0]           burst;
   logic [IDX_W-1:0]      beat_idx;
   logic [DATA_WIDTH-1:0] beats [NUM_BEATS];
   logic [DATA_WIDTH-1:0] beat_raw;
   logic [DATA_WIDTH-1:0] beat_out;

   logic aw_v, w_v, b_r, busy, done;
   logic aw_hs, w_hs, b_hs, last_beat;

   assign clamp = (num_beats_i > CNT_W'(NUM_BEATS)) ?
                  CNT_W'(NUM_BEATS) : num_beats_i;

   assign cur_addr = base_q + (ADDR_WIDTH'(sent_q) << OFF_W);
   assign to_bound = (13'h1000 - {1'b0, cur_addr[11:0]}) >> OFF_W;
   assign rem      = 13'(total_q - sent_q);

   always_comb begin
      burst = 13'(MAX_BURST_LEN);
      if (rem < burst)      burst = rem;
      if (to_bound < burst) burst = to_bound;
   end

   // Global beat k is the k-th slice counted from the tile MSB.
   for (genvar b = 0; b < NUM_BEATS; b++) begin : g_beat
      assign beats[b] = tile_q[TILE_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH];
   end

   assign beat_idx = IDX_W'(sent_q + CNT_W'(beat_q));
   assign beat_raw = beats[beat_idx];

   if (REVERSE_LANES) begin : g_rev
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign beat_out[l*DATA_PRECISION +: DATA_PRECISION] =
            beat_raw[(LANES-1-l)*DATA_PRECISION +: DATA_PRECISION];
      end
   end else begin : g_fwd
      assign beat_out = beat_raw;
   end

   assign aw_hs     = (state_q == S_AW) && axi.awready;
   assign w_hs      = (state_q == S_W) && axi.wready;
   assign b_hs      = (state_q == S_B) && axi.bvalid;
   assign last_beat = (beat_q == len_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      aw_v    = 1'b0;
      w_v     = 1'b0;
      b_r     = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i)
               state_d = (clamp != '0) ? S_AW : S_DONE;
         end
         S_AW: begin
            aw_v = 1'b1;
            busy = 1'b1;
            if (aw_hs) state_d = S_W;
         end
         S_W: begin
            w_v  = 1'b1;
            busy = 1'b1;
            if (w_hs && last_beat) state_d = S_B;
         end
         S_B: begin
            b_r  = 1'b1;
            busy = 1'b1;
            if (b_hs)
               state_d = (sent_q < total_q) ? S_AW : S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tile_q  <= '0;
         base_q  <= '0;
         total_q <= '0;
         sent_q  <= '0;
         beat_q  <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  tile_q  <= tile_i;
                  base_q  <= {base_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  total_q <= clamp;
                  sent_q  <= '0;
                  beat_q  <= '0;
                  err_q   <= 1'b0;
               end
            end
            S_AW: begin
               if (aw_hs) begin
                  len_q  <= 8'(burst - 13'd1);
                  beat_q <= '0;
               end
            end
            S_W: begin
               if (w_hs) begin
                  if (last_beat) begin
                     sent_q <= sent_q + CNT_W'(len_q) + CNT_W'(1);
                     beat_q <= '0;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                  end
               end
            end
            S_B: begin
               if (b_hs && (axi.bresp != 2'b00)) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign axi.awvalid = aw_v;
   assign axi.awaddr  = aw_v ? cur_addr : '0;
   assign axi.awlen   = aw_v ? 8'(burst - 13'd1) : 8'd0;
   assign axi.wvalid  = w_v;
   assign axi.wdata   = w_v ? beat_out : '0;
   assign axi.wstrb   = {(DATA_WIDTH/8){w_v}};
   assign axi.wlast   = w_v && last_beat;
   assign axi.bready  = b_r;

   assign busy_o = busy;
   assign done_o = done;
   assign err_o  = err_q;

endmodule

// File: tb/tb_gemm_tile_writer.sv
// Directed bench for gemm_tile_writer: emulates the AXI slave and checks
// burst split, beat order, lane reversal, backpressure, errors and resets.
module tb_gemm_tile_writer;

   localparam int AW = 32;
   localparam int DW = 1024;
   localparam int TW = 16384;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [4:0]    num_beats_i;
   logic [TW-1:0] tile_i;
   logic          busy_o, done_o, err_o;

   gemm_tile_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   gemm_tile_writer dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .num_beats_i (num_beats_i),
      .tile_i      (tile_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .axi         (axi)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] aw_addr_q [$];
   logic [7:0]    aw_len_q  [$];
   logic [DW-1:0] w_data_q  [$];
   logic          w_last_q  [$];
   int            done_pulses, done_cycle, stall_viol, aw_seen;
   bit            timeout, busy_at_done;
   logic          err_pre, err_post;

   function automatic logic [TW-1:0] make_tile(input int seed);
      logic [TW-1:0] t;
      for (int e = 0; e < 1024; e++) t[e*16 +: 16] = 16'(e*3 + seed*257);
      return t;
   endfunction

   function automatic logic [DW-1:0] exp_beat(input logic [TW-1:0] t, input int k);
      logic [DW-1:0] s, r;
      s = t[TW-1-k*DW -: DW];
      for (int i = 0; i < 64; i++) r[i*16 +: 16] = s[(63-i)*16 +: 16];
      return r;
   endfunction

   task automatic do_start(input logic [AW-1:0] base, input logic [4:0] n,
                           input logic [TW-1:0] t);
      start_i = 1'b1;
      base_addr_i = base;
      num_beats_i = n;
      tile_i = t;
      @(negedge clk);
      start_i = 1'b0;
      tile_i = ~t;
      base_addr_i = '1;
      num_beats_i = '0;
   endtask

   task automatic run_xfer(input int aw_delay, input bit w_toggle,
                           input logic [1:0] bresp_first, input bit hold_start,
                           input int stop_beats, input int max_cycles);
      int cyc = 0, aw_wait = 0, pend_b = 0, b_cnt = 0, after = 0;
      bit phase = 1'b1, fin = 1'b0, done_seen = 1'b0, err_next = 1'b0;
      bit aw_st = 1'b0, w_st = 1'b0, w_hs;
      logic [AW-1:0] aa_prev = '0;
      logic [7:0]    al_prev = '0;
      logic [DW-1:0] wd_prev = '0;
      logic          wl_prev = 1'b0;
      aw_addr_q.delete(); aw_len_q.delete();
      w_data_q.delete();  w_last_q.delete();
      done_pulses = 0; done_cycle = -1; stall_viol = 0; aw_seen = 0;
      timeout = 1'b0; busy_at_done = 1'b0; err_pre = 1'bx; err_post = 1'bx;
      while (!fin) begin
         if (err_next) begin err_post = err_o; err_next = 1'b0; end
         if (aw_st && (axi.awvalid !== 1'b1 || axi.awaddr !== aa_prev ||
                       axi.awlen !== al_prev)) stall_viol++;
         if (w_st && (axi.wvalid !== 1'b1 || axi.wdata !== wd_prev ||
                      axi.wlast !== wl_prev)) stall_viol++;
         if (axi.awvalid) aw_seen++;
         if (done_o) begin
            done_pulses++;
            if (busy_o) busy_at_done = 1'b1;
            if (!done_seen) done_cycle = cyc;
            done_seen = 1'b1;
         end
         if (stop_beats >= 0 && w_data_q.size() == stop_beats && axi.wvalid) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
            return;
         end
         start_i = hold_start && !done_seen;
         axi.awready = axi.awvalid && (aw_wait >= aw_delay);
         if (axi.awvalid) aw_wait++;
         axi.wready = w_toggle ? phase : 1'b1;
         phase = !phase;
         axi.bvalid = (pend_b > 0);
         axi.bresp = (b_cnt == 0) ? bresp_first : 2'b00;
         aw_st = axi.awvalid && !axi.awready;
         aa_prev = axi.awaddr; al_prev = axi.awlen;
         if (axi.awvalid && axi.awready) begin
            aw_addr_q.push_back(axi.awaddr);
            aw_len_q.push_back(axi.awlen);
            aw_wait = 0;
         end
         w_st = axi.wvalid && !axi.wready;
         wd_prev = axi.wdata; wl_prev = axi.wlast;
         w_hs = axi.wvalid && axi.wready;
         if (axi.bvalid && axi.bready) begin
            if (b_cnt == 0) begin err_pre = err_o; err_next = 1'b1; end
            b_cnt++; pend_b--;
         end
         if (w_hs) begin
            w_data_q.push_back(axi.wdata);
            w_last_q.push_back(axi.wlast);
            if (axi.wlast) pend_b++;
         end
         if (done_seen) begin after++; if (after > 3) fin = 1'b1; end
         cyc++;
         if (cyc > max_cycles) begin timeout = 1'b1; fin = 1'b1; end
         @(negedge clk);
      end
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      axi.bresp = 2'b00; start_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy_o, done_o, err_o, axi.awvalid, axi.wvalid, axi.bready, axi.wlast} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b want 0000000", {busy_o, done_o, err_o, axi.awvalid, axi.wvalid, axi.bready, axi.wlast});
      end
      reset_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (axi.awaddr !== '0 || axi.awlen !== '0 || axi.wstrb !== '0 || axi.wdata !== '0) begin
         n_errors++;
         $display("FAIL reset_bus: awaddr=%h awlen=%h wstrb_lo=%h want all 0", axi.awaddr, axi.awlen, axi.wstrb[15:0]);
      end
   endtask

   task automatic test_full_tile();
      logic [TW-1:0] t = make_tile(1);
      do_start(32'h1000, 5'd16, t);
      n_checks++;
      if (busy_o !== 1'b1) begin n_errors++; $display("FAIL full_busy: got %b want 1", busy_o); end
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 200);
      n_checks++;
      if (timeout) begin n_errors++; $display("FAIL full_timeout: got 1 want 0"); end
      n_checks++;
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h1000 || aw_len_q[0] !== 8'd7) begin
         n_errors++; $display("FAIL full_aw0: n=%0d want AW 0x1000 len 7", aw_addr_q.size());
      end
      n_checks++;
      if (aw_addr_q.size() != 2 || aw_addr_q[1] !== 32'h1400 || aw_len_q[1] !== 8'd7) begin
         n_errors++; $display("FAIL full_aw1: n=%0d want AW 0x1400 len 7", aw_addr_q.size());
      end
      n_checks++;
      if (w_data_q.size() != 16) begin
         n_errors++; $display("FAIL full_nbeats: got %0d want 16", w_data_q.size());
      end
      for (int k = 0; k < w_data_q.size() && k < 16; k++) begin
         n_checks++;
         if (w_data_q[k] !== exp_beat(t, k) || w_last_q[k] !== (k == 7 || k == 15)) begin
            n_errors++;
            $display("FAIL full_beat%0d: data_lo=%h last=%b want data_lo=%h last=%b",
                     k, w_data_q[k][63:0], w_last_q[k], exp_beat(t, k)[63:0], (k == 7 || k == 15));
         end
      end
      n_checks++;
      if (w_data_q.size() < 1 || w_data_q[0][15:0] !== 16'h0CFE || w_data_q[0][1023:1008] !== 16'h0C41) begin
         n_errors++; $display("FAIL full_lanes: beat0 lane0/lane63 not 0cfe/0c41");
      end
      n_checks++;
      if (done_pulses != 1 || busy_at_done || err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL full_done: pulses=%0d busy_at_done=%b err=%b want 1 0 0", done_pulses, busy_at_done, err_o);
      end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] t = make_tile(2);
      do_start(32'h1000, 5'd16, t);
      run_xfer(3, 1'b1, 2'b00, 1'b0, -1, 400);
      n_checks++;
      if (timeout || stall_viol != 0) begin
         n_errors++; $display("FAIL bp_stable: timeout=%b violations=%0d want 0 0", timeout, stall_viol);
      end
      n_checks++;
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h1000 || aw_addr_q[1] !== 32'h1400) begin
         n_errors++; $display("FAIL bp_aw: n=%0d want 0x1000 0x1400", aw_addr_q.size());
      end
      n_checks++;
      if (w_data_q.size() != 16) begin
         n_errors++; $display("FAIL bp_nbeats: got %0d want 16", w_data_q.size());
      end
      for (int k = 0; k < w_data_q.size() && k < 16; k++) begin
         n_checks++;
         if (w_data_q[k] !== exp_beat(t, k)) begin
            n_errors++;
            $display("FAIL bp_beat%0d: data_lo=%h want %h", k, w_data_q[k][63:0], exp_beat(t, k)[63:0]);
         end
      end
   endtask

   task automatic test_4k_split();
      logic [TW-1:0] t = make_tile(3);
      do_start(32'h0F80, 5'd4, t);
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 100);
      n_checks++;
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h0F80 || aw_len_q[0] !== 8'd0 ||
          aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd2) begin
         n_errors++; $display("FAIL split_aw: n=%0d want 0xf80/0 then 0x1000/2", aw_addr_q.size());
      end
      n_checks++;
      if (w_data_q.size() != 4) begin
         n_errors++; $display("FAIL split_nbeats: got %0d want 4", w_data_q.size());
      end
      for (int k = 0; k < w_data_q.size() && k < 4; k++) begin
         n_checks++;
         if (w_data_q[k] !== exp_beat(t, k) || w_last_q[k] !== (k == 0 || k == 3)) begin
            n_errors++;
            $display("FAIL split_beat%0d: data_lo=%h last=%b want %h %b",
                     k, w_data_q[k][63:0], w_last_q[k], exp_beat(t, k)[63:0], (k == 0 || k == 3));
         end
      end
   endtask

   task automatic test_error();
      do_start(32'h3000, 5'd16, make_tile(4));
      run_xfer(0, 1'b0, 2'b10, 1'b0, -1, 200);
      n_checks++;
      if (err_pre !== 1'b0 || err_post !== 1'b1) begin
         n_errors++; $display("FAIL err_timing: before=%b after=%b want 0 1", err_pre, err_post);
      end
      n_checks++;
      if (aw_addr_q.size() != 2 || done_pulses != 1 || err_o !== 1'b1) begin
         n_errors++;
         $display("FAIL err_cont: bursts=%0d done=%0d err=%b want 2 1 1", aw_addr_q.size(), done_pulses, err_o);
      end
      do_start(32'h3000, 5'd2, make_tile(4));
      n_checks++;
      if (err_o !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b want 0", err_o); end
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 100);
      n_checks++;
      if (err_o !== 1'b0 || done_pulses != 1) begin
         n_errors++; $display("FAIL err_clean: err=%b done=%0d want 0 1", err_o, done_pulses);
      end
   endtask

   task automatic test_edge_counts();
      do_start(32'h1000, 5'd0, make_tile(7));
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 20);
      n_checks++;
      if (aw_seen != 0 || done_pulses != 1 || done_cycle != 0) begin
         n_errors++;
         $display("FAIL zero_beats: awvalid=%0d done=%0d at=%0d want 0 1 0", aw_seen, done_pulses, done_cycle);
      end
      do_start(32'h1000, 5'd20, make_tile(7));
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 200);
      n_checks++;
      if (w_data_q.size() != 16 || aw_len_q.size() != 2 || aw_len_q[1] !== 8'd7) begin
         n_errors++; $display("FAIL clamp: beats=%0d bursts=%0d want 16 2", w_data_q.size(), aw_len_q.size());
      end
      do_start(32'h1000, 5'd16, make_tile(7));
      run_xfer(0, 1'b0, 2'b00, 1'b1, -1, 200);
      n_checks++;
      if (w_data_q.size() != 16 || aw_addr_q.size() != 2 || done_pulses != 1) begin
         n_errors++;
         $display("FAIL start_held: beats=%0d bursts=%0d done=%0d want 16 2 1", w_data_q.size(), aw_addr_q.size(), done_pulses);
      end
      do_start(32'h2003, 5'd1, make_tile(7));
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 50);
      n_checks++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h2000 || aw_len_q[0] !== 8'd0 ||
          w_last_q.size() != 1 || w_last_q[0] !== 1'b1) begin
         n_errors++; $display("FAIL align_one: bursts=%0d want AW 0x2000 len 0 with wlast", aw_addr_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [TW-1:0] t = make_tile(6);
      do_start(32'h1000, 5'd16, make_tile(5));
      run_xfer(0, 1'b0, 2'b00, 1'b0, 3, 100);
      n_checks++;
      if (w_data_q.size() != 3 || axi.wvalid !== 1'b1) begin
         n_errors++; $display("FAIL rst_reach: beats=%0d wvalid=%b want 3 1", w_data_q.size(), axi.wvalid);
      end
      reset_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_o, done_o, err_o, axi.awvalid, axi.wvalid, axi.bready, axi.wlast} !== 7'b0 ||
          axi.wdata !== '0 || axi.wstrb !== '0 || axi.awaddr !== '0) begin
         n_errors++;
         $display("FAIL rst_mid: ctrl=%b want 0000000 and zero buses", {busy_o, done_o, err_o, axi.awvalid, axi.wvalid, axi.bready, axi.wlast});
      end
      reset_i = 1'b0;
      @(negedge clk);
      do_start(32'h2000, 5'd16, t);
      run_xfer(0, 1'b0, 2'b00, 1'b0, -1, 200);
      n_checks++;
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h2000 || aw_addr_q[1] !== 32'h2400 ||
          w_data_q.size() != 16 || done_pulses != 1) begin
         n_errors++;
         $display("FAIL rst_resume: bursts=%0d beats=%0d done=%0d want 2 16 1", aw_addr_q.size(), w_data_q.size(), done_pulses);
      end
      n_checks++;
      if (w_data_q.size() != 16 || w_data_q[0] !== exp_beat(t, 0) || w_data_q[15] !== exp_beat(t, 15)) begin
         n_errors++; $display("FAIL rst_data: first/last beat of resumed tile differ");
      end
   endtask

   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      base_addr_i = '0;
      num_beats_i = '0;
      tile_i = '0;
      axi.awready = 1'b0;
      axi.wready = 1'b0;
      axi.bvalid = 1'b0;
      axi.bresp = 2'b00;
      test_reset();
      test_full_tile();
      test_backpressure();
      test_4k_split();
      test_error();
      test_edge_counts();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
